// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression controller and datapath.
// Holds the FSM state encoding, schedule boundary and the initial hash value.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int ROUNDS_DEFAULT = 64;
    localparam int SCHED_DIRECT   = 16;

    // Element [7] is H0, element [0] is H7.
    localparam logic [7:0][31:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_INIT) || (s == ST_ROUND) || (s == ST_FINAL);
    endfunction

endpackage

// File: rtl/sha256_compress_ctrl_if.sv
// Control bundle between the block producer/consumer and the compression controller.
// The slave modport is the controller side.
interface sha256_compress_ctrl_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic             first_block;
    logic             abort;
    logic             out_ready;
    logic             start_ready;
    logic             load_iv;
    logic             load_work;
    logic             round_en;
    logic [IDX_W-1:0] round_idx;
    logic             w_expand;
    logic             add_en;
    logic             out_valid;
    logic             busy;

    modport master (
        output start, first_block, abort, out_ready,
        input  start_ready, load_iv, load_work, round_en, round_idx,
               w_expand, add_en, out_valid, busy
    );

    modport slave (
        input  start, first_block, abort, out_ready,
        output start_ready, load_iv, load_work, round_en, round_idx,
               w_expand, add_en, out_valid, busy
    );
endinterface

// File: rtl/sha256_round_counter.sv
// Round counter for the compression core: clear, enable, terminal flag at ROUNDS-1.
// Saturates at the terminal count; the next value is exported so outputs can be registered.
module sha256_round_counter #(
    parameter int ROUNDS = 64,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_s,
    input  logic             en_s,
    output logic [IDX_W-1:0] count_r,
    output logic [IDX_W-1:0] count_nxt_s,
    output logic             terminal_s
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    assign terminal_s = (count_r == LAST_IDX);

    // Next count: clear dominates, increment only below the terminal count.
    always_comb begin
        count_nxt_s = count_r;
        if (clr_s) begin
            count_nxt_s = {IDX_W{1'b0}};
        end else if (en_s && !terminal_s) begin
            count_nxt_s = count_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {IDX_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end
endmodule

// File: rtl/sha256_compress_ctrl.sv
// Sequencing controller for the SHA-256 compression datapath: INIT, ROUNDS rounds,
// FINAL accumulate, then a held result-valid. Outputs are registered from the next state.
module sha256_compress_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    sha256_compress_ctrl_if.slave  bus
);
    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             fb_r;
    logic             fb_nxt_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic [IDX_W-1:0] count_r;
    logic [IDX_W-1:0] count_nxt_s;
    logic             terminal_s;

    logic             start_ready_r;
    logic             load_iv_r;
    logic             load_work_r;
    logic             round_en_r;
    logic [IDX_W-1:0] round_idx_r;
    logic             w_expand_r;
    logic             add_en_r;
    logic             out_valid_r;
    logic             busy_r;

    sha256_round_counter #(
        .ROUNDS (ROUNDS),
        .IDX_W  (IDX_W)
    ) u_round_counter (
        .clk         (clk),
        .rst         (rst),
        .clr_s       (cnt_clr_s),
        .en_s        (cnt_en_s),
        .count_r     (count_r),
        .count_nxt_s (count_nxt_s),
        .terminal_s  (terminal_s)
    );

    // Next-state, start acceptance, first_block latch and counter control.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        if (bus.abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_nxt_s = ST_INIT;
                        accept_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_INIT:  state_nxt_s = ST_ROUND;
                ST_ROUND: begin
                    if (terminal_s) begin
                        state_nxt_s = ST_FINAL;
                    end else begin
                        state_nxt_s = ST_ROUND;
                    end
                end
                ST_FINAL: state_nxt_s = ST_DONE;
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default:  state_nxt_s = ST_IDLE;
            endcase
        end

        if (accept_s) begin
            fb_nxt_s = bus.first_block;
        end else begin
            fb_nxt_s = fb_r;
        end

        // The count is held at zero everywhere except while rounds are running.
        cnt_clr_s = (state_nxt_s != ST_ROUND);
        cnt_en_s  = (state_r == ST_ROUND) && (state_nxt_s == ST_ROUND);
    end

    // State, latch and registered Moore outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            fb_r          <= 1'b0;
            start_ready_r <= 1'b1;
            load_iv_r     <= 1'b0;
            load_work_r   <= 1'b0;
            round_en_r    <= 1'b0;
            round_idx_r   <= {IDX_W{1'b0}};
            w_expand_r    <= 1'b0;
            add_en_r      <= 1'b0;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            fb_r          <= fb_nxt_s;
            start_ready_r <= (state_nxt_s == ST_IDLE);
            load_iv_r     <= (state_nxt_s == ST_INIT) && fb_nxt_s;
            load_work_r   <= (state_nxt_s == ST_INIT);
            round_en_r    <= (state_nxt_s == ST_ROUND);
            round_idx_r   <= (state_nxt_s == ST_ROUND) ? count_nxt_s : {IDX_W{1'b0}};
            w_expand_r    <= (state_nxt_s == ST_ROUND) &&
                             (count_nxt_s >= IDX_W'(SCHED_DIRECT));
            add_en_r      <= (state_nxt_s == ST_FINAL);
            out_valid_r   <= (state_nxt_s == ST_DONE);
            busy_r        <= is_busy_state(state_nxt_s);
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.load_iv     = load_iv_r;
    assign bus.load_work   = load_work_r;
    assign bus.round_en    = round_en_r;
    assign bus.round_idx   = round_idx_r;
    assign bus.w_expand    = w_expand_r;
    assign bus.add_en      = add_en_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.busy        = busy_r;
endmodule

// File: doc/sha256_compress_ctrl.md
# sha256_compress_ctrl

Sequencing controller for the SHA-256 compression datapath in the miner core. It accepts one 512-bit block per start handshake and drives the working-variable load, the message-schedule source select and the round-constant index. It steps the round datapath through exactly ROUNDS rounds, fires the final hash accumulate, and holds a result-valid handshake until the consumer takes it. It owns round counting for the core; the datapath contains no counter of its own.

## Interface
- ROUNDS, 64, compression rounds per block; must be a power of two, at least 17.
- IDX_W, $clog2(ROUNDS), width of the round index.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- start  in  1  request to compress one block; accepted only while start_ready=1.
- first_block  in  1  sampled with an accepted start. 1 means the hash registers are initialised from the SHA-256 IV; 0 means the chained H is used.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- out_ready  in  1  consumer accepts the result.
- start_ready  out  1  high only in IDLE.
- load_iv  out  1  one-cycle pulse in INIT when the latched first_block=1.
- load_work  out  1  one-cycle pulse in INIT; copies H into a..h.
- round_en  out  1  high during every ROUND cycle.
- round_idx  out  IDX_W  current round number; also the K-ROM address.
- w_expand  out  1  in ROUND: 0 selects message word round_idx (rounds 0..15), 1 selects the expanded schedule word.
- add_en  out  1  one-cycle pulse in FINAL; performs H += a..h.
- out_valid  out  1  high in DONE.
- busy  out  1  high in INIT, ROUND and FINAL.

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE, held in a 3-bit enum.
- IDLE: start=1 and abort=0 causes a transition to INIT and latches first_block. Otherwise the block stays in IDLE.
- INIT: asserts load_work, and load_iv if the latched first_block is set. The round counter is cleared to 0. Always advances to ROUND.
- ROUND: asserts round_en.
  - round_idx increments by 1 each cycle, from 0 up to ROUNDS-1.
  - w_expand = (round_idx >= 16).
  - When round_idx == ROUNDS-1, the next state is FINAL.
  - The counter never wraps inside ROUND; it saturates at ROUNDS-1 until it is cleared.
- FINAL: asserts add_en for exactly one cycle, then moves to DONE.
- DONE: asserts out_valid. out_ready=1 moves to IDLE; without it, DONE is held indefinitely with outputs stable.
- abort=1 in any state: next state is IDLE and the counter clears. No add_en fires if FINAL has not been reached. The hash registers keep their prior value, so the datapath may hold partially updated working variables.
- Simultaneous events:
  - start and abort in IDLE: abort wins and the start is dropped.
  - out_ready and abort in DONE: the result is IDLE either way.
  - start while not in IDLE: ignored, not queued.
- Outputs other than the state-decoded strobes are zero outside their states. round_idx reads 0 outside ROUND.

## Timing
- Reset values: state=IDLE, counter=0, first_block latch=0. start_ready=1; all other outputs are 0.
- Reset asserted mid-operation: immediate return to IDLE with the reset values; no pulses emitted.
- Start accepted at edge t:
  - INIT is present during cycle t+1.
  - ROUND covers cycles t+2 .. t+ROUNDS+1.
  - FINAL is at cycle t+ROUNDS+2.
  - out_valid is first high in cycle t+ROUNDS+3.
  - With ROUNDS=64, that is 67 cycles from the accept edge to out_valid.
- Back-to-back throughput: out_ready at edge u gives IDLE at u+1. The earliest next accept is at edge u+1. Minimum period is ROUNDS+4 cycles per block.
- All outputs are Moore, decoded from registered state and counter; no combinational path from input to output.

## Structure
- sha256_pkg holds:
  - the state enum;
  - the ROUNDS_DEFAULT and SCHED_DIRECT (16) constants;
  - the eight IV words, for use by the datapath under load_iv.
- Sub-module sha256_round_counter: IDX_W-bit counter with clear, enable and terminal flag (count == ROUNDS-1), saturating at the terminal count. It is instantiated once.
- The FSM stays in the top file.

## Test plan
- Reset, then start=1 with first_block=1 at edge 0, out_ready held 1:
  - load_iv and load_work are high in cycle 1;
  - round_idx runs 0..63 over cycles 2..65, with w_expand rising at round 16;
  - add_en in cycle 66, out_valid in cycle 67, start_ready back in cycle 68.
- Second block with first_block=0: load_iv stays 0 and load_work pulses. Hold out_ready=0 for 10 cycles; out_valid stays high and all other outputs are 0 until ready.
- abort=1 at round_idx=37: IDLE on the next cycle, round_idx=0, add_en never asserts. A subsequent start restarts from round 0.
- start=1 during ROUND and during DONE: ignored, no extra blocks. start and abort together in IDLE: remains in IDLE.
- rst asserted asynchronously mid-ROUND (round_idx=20): all outputs return to their reset values before the next clock edge. After rst is released, a normal start completes in 67 cycles.
